divider: RTL
============

DIVIDER -- requirements
Module: divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, setting the operand and result width in bits.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid  input  1  dividend/divisor valid.
REQ-005 The block SHALL have port in_ready  output  1  block can accept an operand pair.
REQ-006 The block SHALL have port dividend  input  WIDTH  unsigned numerator.
REQ-007 The block SHALL have port divisor  input  WIDTH  unsigned denominator.
REQ-008 The block SHALL have port out_valid  output  1  result valid.
REQ-009 The block SHALL have port out_ready  input  1  consumer accepts the result.
REQ-010 The block SHALL have port quotient  output  WIDTH  unsigned floor(dividend/divisor).
REQ-011 The block SHALL have port remainder  output  WIDTH  unsigned dividend mod divisor.
REQ-012 The block SHALL have port div_by_zero  output  1  the current result came from divisor == 0.

Function
REQ-013 The block SHALL implement a three-state FSM: IDLE, BUSY, DONE.
REQ-014 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-015 An input handshake (in_valid && in_ready at a rising edge) SHALL capture dividend and divisor. The FSM SHALL go to BUSY with an iteration counter of WIDTH, or go directly to DONE if divisor == 0.
REQ-016 In BUSY, each cycle SHALL perform one restoring shift-subtract step, quotient MSB first: shift the partial remainder left and bring in the next dividend bit. If partial remainder >= divisor, subtract and set the quotient bit to 1; otherwise set it to 0.
REQ-017 The partial remainder datapath SHALL be WIDTH+1 bits wide so no step overflows; remainder SHALL output its low WIDTH bits.
REQ-018 After exactly WIDTH BUSY cycles the FSM SHALL enter DONE, so out_valid rises WIDTH+1 edges after the accepting edge for every nonzero divisor.
REQ-019 For divisor == 0, the block SHALL set quotient to all ones, set remainder to the dividend, set div_by_zero to 1, and raise out_valid one edge after acceptance.
REQ-020 For a nonzero divisor, div_by_zero SHALL be 0.
REQ-021 In DONE, quotient, remainder and div_by_zero SHALL hold stable while out_ready is 0, for any number of cycles.
REQ-022 An output handshake (out_valid && out_ready at an edge) SHALL return the FSM to IDLE. No new operand is accepted in that same edge, so back-to-back operations issue every WIDTH+2 cycles.
REQ-023 in_valid asserted while in BUSY or DONE SHALL be ignored and SHALL not corrupt the operation in flight.
REQ-024 Operand inputs SHALL be sampled only on the accepting edge; later changes SHALL not affect the result.

Reset
REQ-025 On rst high at a rising edge, the FSM SHALL go to IDLE and the counter and partial-remainder state SHALL clear.
REQ-026 On that same reset edge, quotient, remainder and div_by_zero SHALL be set to 0.
REQ-027 Reset during BUSY or DONE SHALL abandon the operation with no out_valid pulse; in_ready SHALL be 1 in the cycle after reset deasserts.
REQ-028 rst SHALL take priority over any simultaneous handshake.

Structure
REQ-029 Package divider_pkg SHALL hold the FSM state enum (IDLE, BUSY, DONE) and the default WIDTH constant.
REQ-030 One combinational sub-module, divider_step, SHALL implement a single shift-compare-subtract iteration. Inputs: partial remainder, next dividend bit, divisor. Outputs: new partial remainder and quotient bit.
REQ-031 The iteration counter SHALL be $clog2(WIDTH+1) bits wide.

Verification (WIDTH=8)
REQ-032 100/7 with out_ready=1 -> quotient=14, remainder=2, div_by_zero=0; out_valid 9 edges after accept.
REQ-033 255/1 -> quotient=255, remainder=0; then 5/9 -> quotient=0, remainder=5.
REQ-034 42/0 -> quotient=255, remainder=42, div_by_zero=1; out_valid 1 edge after accept.
REQ-035 200/3 with out_ready=0 for 20 cycles -> quotient=66, remainder=2 held stable and out_valid held 1; in_valid pulses during the hold are ignored.
REQ-036 rst asserted 4 cycles into a BUSY operation -> no out_valid; next 9/3 -> quotient=3, remainder=0.
REQ-037 Random sweep of 10,000 operand pairs, including 0 and 255, against a reference model with random out_ready stalls -> all results match.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: state_t (IDLE/BUSY/DONE) and DIV_WIDTH, the default operand width.
package divider_pkg;

  localparam int DIV_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/divider_step.sv
// One restoring division iteration: shift in a dividend bit, compare, subtract.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
// Ports: rem_in  - current partial remainder (WIDTH+1 bits)
//        next_bit - next dividend bit, MSB first
//        divisor  - unsigned divisor
//        rem_out  - updated partial remainder (WIDTH+1 bits)
//        q_bit    - quotient bit produced by this iteration
module divider_step
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             next_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  // One extra bit above the remainder width so the shifted value never wraps
  // before the comparison.
  logic [WIDTH+1:0] shifted;
  logic [WIDTH+1:0] dvs_ext;

  always_comb begin
    shifted = {rem_in, next_bit};
    dvs_ext = {2'b00, divisor};
    q_bit   = (shifted >= dvs_ext);
    // The partial remainder stays below the divisor, so the result always
    // fits back into WIDTH+1 bits.
    rem_out = q_bit ? (WIDTH+1)'(shifted - dvs_ext) : (WIDTH+1)'(shifted);
  end

endmodule

// File: rtl/divider.sv
// Unsigned sequential divider, one restoring iteration per cycle.
// Latency: WIDTH+1 edges from accept to out_valid (1 edge when divisor == 0).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
// Ports: clk, rst (sync, active-high); in_valid/in_ready with dividend and
//        divisor; out_valid/out_ready with quotient, remainder, div_by_zero.
module divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [WIDTH:0]   rem_q,   rem_d;
  // Shared shift register: dividend bits leave at the top while quotient
  // bits enter at the bottom, so after WIDTH steps it holds the quotient.
  logic [WIDTH-1:0] dq_q,    dq_d;
  logic [WIDTH-1:0] dvs_q,   dvs_d;
  logic             dz_q,    dz_d;

  logic [WIDTH:0]   step_rem;
  logic             step_q;

  divider_step #(.WIDTH(WIDTH)) u_step (
    .rem_in   (rem_q),
    .next_bit (dq_q[WIDTH-1]),
    .divisor  (dvs_q),
    .rem_out  (step_rem),
    .q_bit    (step_q)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    dq_d    = dq_q;
    dvs_d   = dvs_q;
    dz_d    = dz_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          dvs_d = divisor;
          if (divisor == '0) begin
            dz_d    = 1'b1;
            dq_d    = '1;
            rem_d   = {1'b0, dividend};
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            dz_d    = 1'b0;
            dq_d    = dividend;
            rem_d   = '0;
            cnt_d   = CNT_W'(WIDTH);
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        rem_d = step_rem;
        dq_d  = WIDTH'({dq_q, step_q});
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      dq_q    <= '0;
      dvs_q   <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      dq_q    <= dq_d;
      dvs_q   <= dvs_d;
      dz_q    <= dz_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = dq_q;
  assign remainder   = rem_q[WIDTH-1:0];
  assign div_by_zero = dz_q;

endmodule
